lac_host: RTL and testbench

Host-side controller for the logic-analyzer UART protocol: issues the arm command sequence (arm, select, mask, compare, pretrigger), waits for the capture dump, and delivers the dumped samples on a ready/valid stream. It also issues disarm on request. It sits in bench/bring-up designs as the far end of the analyzer's UART link, so an on-board or simulated master can drive captures without a PC.

---
 rtl/lac_pkg.sv | 7 +
 rtl/lac_host_uart.sv | 90 +++++++++
 rtl/lac_host.sv | 160 ++++++++++++++++
 tb/tb_lac_host.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lac_pkg.sv
// lac_pkg: shared command bytes and host state encoding for the analyzer UART protocol
package lac_pkg;
  localparam logic [7:0] cmd_arm = 8'h01;
  localparam logic [7:0] cmd_disarm = 8'h02;
  localparam logic [7:0] cmd_nop = 8'h20;
  typedef enum logic [2:0] {IDLE, SEND, WAIT_HDR, RECV, DISARM} state_t;
endpackage

// File: rtl/lac_host_uart.sv
// uart: 8N1 transmitter and receiver with a single-byte receive holding register
module uart #(
  parameter int freq_hz = 100000000,
  parameter int baud = 115200
) (
  input  logic       uart_clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       txd,
  input  logic       tx_wr,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  output logic       rx_error,
  input  logic       rx_ack
);
  localparam int div = freq_hz / baud;
  localparam int cw = $clog2(div + 1);
  logic [cw-1:0] tx_cnt, rx_cnt;
  logic [3:0] tx_bit, rx_bit;
  logic [9:0] tx_sh;
  logic [7:0] rx_sh;
  logic [1:0] rx_sync;
  logic rx_bsy;
  assign tx_busy = tx_bit != 4'd0;
  assign txd = tx_busy ? tx_sh[0] : 1'b1;
  // transmit: load start/data/stop frame, shift one bit per baud period
  always_ff @(posedge uart_clk) begin
    if (reset) begin
      tx_bit <= '0;
      tx_cnt <= '0;
      tx_sh <= '1;
    end else if (!tx_busy) begin
      if (tx_wr) begin
        tx_sh <= {1'b1, tx_data, 1'b0};
        tx_bit <= 4'd10;
        tx_cnt <= cw'(div - 1);
      end
    end else if (tx_cnt == '0) begin
      tx_sh <= {1'b1, tx_sh[9:1]};
      tx_bit <= tx_bit - 4'd1;
      tx_cnt <= cw'(div - 1);
    end else begin
      tx_cnt <= tx_cnt - cw'(1);
    end
  end
  // receive: sample mid-bit after start edge; good stop bit fills the holding register
  always_ff @(posedge uart_clk) begin
    if (reset) begin
      rx_sync <= 2'b11;
      rx_bsy <= 1'b0;
      rx_bit <= '0;
      rx_cnt <= '0;
      rx_sh <= '0;
      rx_data <= '0;
      rx_avail <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rxd};
      rx_error <= 1'b0;
      if (rx_ack) rx_avail <= 1'b0;
      if (!rx_bsy) begin
        if (!rx_sync[1]) begin
          rx_bsy <= 1'b1;
          rx_bit <= '0;
          rx_cnt <= cw'(div / 2);
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - cw'(1);
      end else begin
        rx_cnt <= cw'(div - 1);
        rx_bit <= rx_bit + 4'd1;
        if (rx_bit == 4'd0 && rx_sync[1]) begin
          rx_bsy <= 1'b0;
        end else if (rx_bit != 4'd0 && rx_bit < 4'd9) begin
          rx_sh <= {rx_sync[1], rx_sh[7:1]};
        end else if (rx_bit == 4'd9) begin
          rx_bsy <= 1'b0;
          if (rx_sync[1]) begin
            rx_data <= rx_sh;
            rx_avail <= 1'b1;
          end else begin
            rx_error <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: rtl/lac_host.sv
// lac_host: arms the logic analyzer over UART and streams the returned capture dump
module lac_host
  import lac_pkg::*;
#(
  parameter int uart_freq_hz = 100000000,
  parameter int uart_baud = 115200,
  parameter int max_adr_width = 11,
  parameter int timeout_cycles = 1000000
) (
  input  logic                     uart_clk,
  input  logic                     reset,
  input  logic                     uart_rxd,
  output logic                     uart_txd,
  output logic                     uart_cts,
  input  logic                     uart_rts,
  input  logic                     start,
  input  logic                     abort,
  input  logic [7:0]               cfg_select,
  input  logic [7:0]               cfg_mask,
  input  logic [7:0]               cfg_cond,
  input  logic [7:0]               cfg_pre,
  output logic                     busy,
  output logic [7:0]               hdr_adr_width,
  output logic                     smp_valid,
  input  logic                     smp_ready,
  output logic [7:0]               smp_data,
  output logic [max_adr_width-1:0] smp_index,
  output logic                     done,
  output logic                     err
);
  localparam int cw = max_adr_width + 1;
  state_t state, state_nx;
  logic tx_wr, tx_busy, rx_avail, rx_error, rx_ack, abort_q;
  logic [7:0] tx_byte, rx_data, c_sel, c_mask, c_cond, c_pre, send_byte;
  logic [2:0] idx;
  logic [cw-1:0] cnt;
  logic [31:0] tcnt;
  logic pending, can_tx, accept, last, hdr_ok, fail;
  logic unused_rts;
  assign unused_rts = uart_rts;
  assign uart_cts = 1'b1;
  uart #(.freq_hz(uart_freq_hz), .baud(uart_baud)) u_uart (
    .uart_clk(uart_clk),
    .reset(reset),
    .rxd(uart_rxd),
    .txd(uart_txd),
    .tx_wr(tx_wr),
    .tx_data(tx_byte),
    .tx_busy(tx_busy),
    .rx_data(rx_data),
    .rx_avail(rx_avail),
    .rx_error(rx_error),
    .rx_ack(rx_ack)
  );
  // state register
  always_ff @(posedge uart_clk) state <= reset ? IDLE : state_nx;
  // next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = abort ? DISARM : start ? SEND : IDLE;
      SEND: state_nx = (can_tx && idx == 3'd4) ? ((abort_q || abort) ? DISARM : WAIT_HDR) : SEND;
      WAIT_HDR: state_nx = pending ? (hdr_ok ? RECV : DISARM) : abort ? DISARM : WAIT_HDR;
      RECV: state_nx = (last || fail) ? IDLE : RECV;
      DISARM: state_nx = can_tx ? IDLE : DISARM;
      default: state_nx = IDLE;
    endcase
  end
  // handshake qualifiers and the arm-sequence byte selected by idx
  always_comb begin
    pending = rx_avail & ~rx_ack;
    can_tx = ~tx_busy & ~tx_wr;
    accept = smp_valid & smp_ready;
    last = accept && cnt == cw'(1);
    hdr_ok = rx_data != 8'd0 && rx_data <= 8'(max_adr_width);
    fail = rx_error || (!pending && !smp_valid && tcnt == 32'(timeout_cycles - 1));
    busy = state != IDLE;
    send_byte = idx == 3'd0 ? cmd_arm : idx == 3'd1 ? c_sel : idx == 3'd2 ? c_mask : idx == 3'd3 ? c_cond : c_pre;
  end
  // datapath: command issue, header decode, sample hand-off and inter-byte timeout
  always_ff @(posedge uart_clk) begin
    if (reset) begin
      tx_wr <= 1'b0;
      tx_byte <= '0;
      rx_ack <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      smp_valid <= 1'b0;
      smp_data <= '0;
      smp_index <= '0;
      hdr_adr_width <= '0;
      cnt <= '0;
      tcnt <= '0;
      idx <= '0;
      abort_q <= 1'b0;
      {c_sel, c_mask, c_cond, c_pre} <= '0;
    end else begin
      tx_wr <= 1'b0;
      rx_ack <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      tcnt <= (state == RECV && !pending && !smp_valid) ? tcnt + 32'd1 : '0;
      case (state)
        IDLE: begin
          if (pending) rx_ack <= 1'b1;
          if (start && !abort) begin
            {c_sel, c_mask, c_cond, c_pre} <= {cfg_select, cfg_mask, cfg_cond, cfg_pre};
            abort_q <= 1'b0;
            tx_wr <= can_tx;
            tx_byte <= cmd_arm;
            idx <= can_tx ? 3'd1 : 3'd0;
          end
        end
        SEND: begin
          if (pending) rx_ack <= 1'b1;
          if (abort) abort_q <= 1'b1;
          if (can_tx) begin
            tx_wr <= 1'b1;
            tx_byte <= send_byte;
            idx <= idx + 3'd1;
          end
        end
        WAIT_HDR: begin
          if (pending) begin
            rx_ack <= 1'b1;
            err <= !hdr_ok;
            if (hdr_ok) begin
              hdr_adr_width <= rx_data;
              cnt <= cw'(1) << rx_data;
              smp_index <= '0;
            end
          end
        end
        RECV: begin
          if (accept) begin
            smp_valid <= 1'b0;
            rx_ack <= 1'b1;
            smp_index <= smp_index + max_adr_width'(1);
            cnt <= cnt - cw'(1);
            done <= last;
          end else if (pending && !smp_valid) begin
            smp_data <= rx_data;
            smp_valid <= 1'b1;
          end
          if (!last && fail) begin
            err <= 1'b1;
            smp_valid <= 1'b0;
          end
        end
        DISARM: begin
          if (can_tx) begin
            tx_wr <= 1'b1;
            tx_byte <= cmd_disarm;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lac_host.sv
// tb_lac_host: analyzer-side serial model with scoreboards for tx commands and dumped samples
module tb_lac_host;
  logic uart_clk = 0, reset = 1, uart_rxd = 1, uart_rts = 0, start = 0, abort = 0, smp_ready = 0;
  logic [7:0] cfg_select = 0, cfg_mask = 0, cfg_cond = 0, cfg_pre = 0;
  logic uart_txd, uart_cts, busy, smp_valid, done, err;
  logic [7:0] hdr_adr_width, smp_data;
  logic [10:0] smp_index;
  int checks = 0, errors = 0, done_cnt = 0, err_cnt = 0;
  logic [7:0] exp_tx[$];
  logic [18:0] exp_smp[$];
  logic [7:0] rx_b;
  logic [18:0] smp_e;

  lac_host #(.uart_freq_hz(1000000), .uart_baud(125000), .max_adr_width(11), .timeout_cycles(400)) dut (
    .uart_clk(uart_clk), .reset(reset), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .uart_cts(uart_cts), .uart_rts(uart_rts), .start(start), .abort(abort),
    .cfg_select(cfg_select), .cfg_mask(cfg_mask), .cfg_cond(cfg_cond), .cfg_pre(cfg_pre),
    .busy(busy), .hdr_adr_width(hdr_adr_width), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .smp_data(smp_data), .smp_index(smp_index), .done(done), .err(err)
  );

  always #5 uart_clk = ~uart_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // bit period is 8 clocks; a 16-clock idle gap follows each byte
  task automatic send_byte(input logic [7:0] b);
    @(negedge uart_clk) uart_rxd = 0;
    repeat (8) @(negedge uart_clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (8) @(negedge uart_clk);
    end
    uart_rxd = 1;
    repeat (24) @(negedge uart_clk);
  endtask

  task automatic wait_for(input string name, input int sel, input int target);
    int ok = 0;
    for (int i = 0; i < 5000 && ok == 0; i++) begin
      @(negedge uart_clk);
      case (sel)
        0: ok = int'(exp_tx.size() == target);
        1: ok = int'(err_cnt == target);
        2: ok = int'(done_cnt == target);
        3: ok = int'(exp_smp.size() == target);
        default: ok = int'(smp_valid == target[0]);
      endcase
    end
    chk(name, ok, 1);
  endtask

  task automatic arm(input logic [7:0] s, input logic [7:0] m, input logic [7:0] c, input logic [7:0] p);
    exp_tx.push_back(8'h01);
    exp_tx.push_back(s);
    exp_tx.push_back(m);
    exp_tx.push_back(c);
    exp_tx.push_back(p);
    @(negedge uart_clk);
    {cfg_select, cfg_mask, cfg_cond, cfg_pre} = {s, m, c, p};
    start = 1;
    @(negedge uart_clk) start = 0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic pulse_abort();
    @(negedge uart_clk) abort = 1;
    @(negedge uart_clk) abort = 0;
  endtask

  // serial decoder for bytes the host sends to the analyzer
  initial forever begin
    @(negedge uart_clk);
    if (!reset && uart_txd === 1'b0) begin
      repeat (4) @(negedge uart_clk);
      for (int i = 0; i < 8; i++) begin
        repeat (8) @(negedge uart_clk);
        rx_b[i] = uart_txd;
      end
      repeat (8) @(negedge uart_clk);
      chk("tx_stop_bit", uart_txd, 1);
      if (exp_tx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected actual=%02h required=none", rx_b);
      end else chk("tx_byte", rx_b, exp_tx.pop_front());
    end
  end

  // sample monitor and pulse counters
  always @(negedge uart_clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (smp_valid && smp_ready) begin
        if (exp_smp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL smp_unexpected actual=%02h required=none", smp_data);
        end else begin
          smp_e = exp_smp.pop_front();
          chk("smp_data", smp_data, smp_e[7:0]);
          chk("smp_index", smp_index, smp_e[18:8]);
        end
      end
    end
  end

  initial begin
    logic [7:0] d;
    int ok;
    repeat (5) @(negedge uart_clk);
    chk("rst_busy", busy, 0);
    chk("rst_txd", uart_txd, 1);
    chk("rst_cts", uart_cts, 1);
    chk("rst_smp_valid", smp_valid, 0);
    chk("rst_smp_data", smp_data, 0);
    chk("rst_smp_index", smp_index, 0);
    chk("rst_hdr", hdr_adr_width, 0);
    chk("rst_done_err", {done, err}, 0);
    reset = 0;
    repeat (5) @(negedge uart_clk);

    arm(8'h03, 8'h0F, 8'h05, 8'h10);
    wait_for("arm_tx_drain", 0, 0);
    repeat (20) @(negedge uart_clk);
    chk("busy_wait_hdr", busy, 1);

    smp_ready = 1;
    for (int i = 0; i < 8; i++) exp_smp.push_back({11'(i), 8'hA0 + 8'(i)});
    send_byte(8'h03);
    for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i));
    wait_for("dump_done", 2, 1);
    chk("dump_busy", busy, 0);
    chk("dump_hdr", hdr_adr_width, 3);
    repeat (20) @(negedge uart_clk);
    chk("dump_done_once", done_cnt, 1);
    chk("dump_smp_drain", exp_smp.size(), 0);

    arm(8'h11, 8'h22, 8'h33, 8'h44);
    wait_for("arm2_tx_drain", 0, 0);
    for (int i = 0; i < 4; i++) exp_smp.push_back({11'(i), 8'hB0 + 8'(i)});
    fork
      begin
        send_byte(8'h02);
        for (int i = 0; i < 4; i++) send_byte(8'hB0 + 8'(i));
      end
      begin
        wait_for("bp_two_taken", 3, 2);
        smp_ready = 0;
        wait_for("bp_valid", 4, 1);
        d = smp_data;
        ok = 1;
        repeat (50) begin
          @(negedge uart_clk);
          if (!smp_valid || smp_data !== d) ok = 0;
        end
        chk("bp_hold", ok, 1);
        chk("bp_held_data", d, 8'hB2);
        smp_ready = 1;
      end
    join
    wait_for("bp_done", 2, 2);
    chk("bp_hdr", hdr_adr_width, 2);
    chk("bp_smp_drain", exp_smp.size(), 0);

    arm(8'h00, 8'h00, 8'h00, 8'h00);
    wait_for("bad_arm_drain", 0, 0);
    exp_tx.push_back(8'h02);
    send_byte(8'h0C);
    wait_for("bad_hdr_err", 1, 1);
    wait_for("bad_hdr_disarm", 0, 0);
    chk("bad_hdr_busy", busy, 0);
    chk("bad_hdr_keep", hdr_adr_width, 2);

    arm(8'h01, 8'h02, 8'h03, 8'h04);
    wait_for("zero_arm_drain", 0, 0);
    exp_tx.push_back(8'h02);
    send_byte(8'h00);
    wait_for("zero_hdr_err", 1, 2);
    wait_for("zero_hdr_disarm", 0, 0);
    chk("zero_hdr_busy", busy, 0);

    arm(8'h55, 8'hAA, 8'h5A, 8'hA5);
    wait_for("abw_arm_drain", 0, 0);
    exp_tx.push_back(8'h02);
    pulse_abort();
    wait_for("abw_disarm", 0, 0);
    repeat (10) @(negedge uart_clk);
    chk("abw_busy", busy, 0);
    chk("abw_no_done", done_cnt, 2);
    chk("abw_no_err", err_cnt, 2);

    arm(8'h07, 8'h08, 8'h09, 8'h0A);
    exp_tx.push_back(8'h02);
    repeat (10) @(negedge uart_clk);
    pulse_abort();
    wait_for("abs_tx_drain", 0, 0);
    repeat (10) @(negedge uart_clk);
    chk("abs_busy", busy, 0);

    exp_tx.push_back(8'h02);
    @(negedge uart_clk) {start, abort} = 2'b11;
    @(negedge uart_clk) {start, abort} = 2'b00;
    wait_for("both_disarm_only", 0, 0);
    repeat (20) @(negedge uart_clk);
    chk("both_busy", busy, 0);

    arm(8'h03, 8'h0F, 8'h05, 8'h10);
    wait_for("to_arm_drain", 0, 0);
    for (int i = 0; i < 4; i++) exp_smp.push_back({11'(i), 8'hC0 + 8'(i)});
    send_byte(8'h03);
    for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i));
    wait_for("to_err", 1, 3);
    chk("to_busy", busy, 0);
    chk("to_smp_valid", smp_valid, 0);
    chk("to_no_done", done_cnt, 2);
    chk("to_smp_drain", exp_smp.size(), 0);

    repeat (50) @(negedge uart_clk);
    chk("final_tx_drain", exp_tx.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
